// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared widths, state encoding and iteration count for the Montgomery reduction stage
package mont_pkg;

    localparam int OP_W   = 256;
    localparam int PROD_W = 512;
    localparam int ACC_W  = 513;

    typedef enum logic [1:0] {
        IDLE,
        RED,
        FSUB,
        HOLD
    } mont_state_e;

    function automatic int digit_count(input int w);
        return OP_W / w;
    endfunction

endpackage

// File: rtl/mont_digit_step.sv
// rtl/mont_digit_step.sv - one combinational word-serial REDC iteration: m from the low digit, then (acc + m*N) >> W
module mont_digit_step
    import mont_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [OP_W-1:0]  n,
    input  logic [W-1:0]     n0_inv,
    output logic [ACC_W-1:0] acc_next
);

    logic [W-1:0]      m;
    logic [W+OP_W-1:0] mn;
    logic [ACC_W-1:0]  sum;

    // m makes the low digit of acc + m*N exactly zero, so the shift loses nothing
    assign m        = acc[W-1:0] * n0_inv;
    assign mn       = {{OP_W{1'b0}}, m} * {{W{1'b0}}, n};
    assign sum      = acc + ACC_W'(mn);
    assign acc_next = sum >> W;

endmodule

// File: rtl/mont_redc_256.sv
// rtl/mont_redc_256.sv - word-serial Montgomery reduction T*2^-256 mod N, one W-bit digit per cycle
// MONT_REDC_LAZY_EN skips the final subtract and returns a result in [0, 2N).
module mont_redc_256
    import mont_pkg::*;
#(
    parameter int W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] t_in,
    input  logic [OP_W-1:0]   n_in,
    input  logic [W-1:0]      n0_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_data
);

    localparam int S  = digit_count(W);
    localparam int CW = $clog2(S + 1);

    mont_state_e      state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [OP_W-1:0]  n_reg;
    logic [W-1:0]     n0_inv_reg;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    assign last_iter = (cnt == CW'(S - 1));

    mont_digit_step #(
        .W(W)
    ) u_step (
        .acc     (acc),
        .n       (n_reg),
        .n0_inv  (n0_inv_reg),
        .acc_next(acc_next)
    );

`ifndef MONT_REDC_LAZY_EN
    logic [OP_W:0] diff;

    // acc < 2N fits in 257 bits; the top bit of the difference is the borrow
    assign diff = acc[OP_W:0] - {1'b0, n_reg};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            acc        <= '0;
            n_reg      <= '0;
            n0_inv_reg <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc        <= {1'b0, t_in};
                        n_reg      <= n_in;
                        n0_inv_reg <= n0_inv;
                        cnt        <= '0;
                        in_ready   <= 1'b0;
                        state      <= RED;
                    end
                end
                RED: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
`ifdef MONT_REDC_LAZY_EN
                        out_data  <= acc_next[OP_W-1:0];
                        out_valid <= 1'b1;
                        state     <= HOLD;
`else
                        state     <= FSUB;
`endif
                    end
                end
`ifndef MONT_REDC_LAZY_EN
                FSUB: begin
                    out_data  <= diff[OP_W] ? acc[OP_W-1:0] : diff[OP_W-1:0];
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_redc_256.sv
// tb/tb_mont_redc_256.sv - randomized self-checking bench for mont_redc_256 (also built with MONT_REDC_LAZY_EN)
module tb_mont_redc_256;

    localparam int W = 64;
`ifdef MONT_REDC_LAZY_EN
    localparam int LAT   = 4;
    localparam int N_RND = 1000;
`else
    localparam int LAT   = 5;
    localparam int N_RND = 40;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] t_in;
    logic [255:0] n_in;
    logic [W-1:0] n0_inv;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;

    int total = 0;
    int bad = 0;
    int sub_hits = 0;

    always #5 clk = ~clk;

    mont_redc_256 #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .t_in     (t_in),
        .n_in     (n_in),
        .n0_inv   (n0_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // N^-1 mod 2^256 by Newton iteration; each step doubles the number of correct bits
    function automatic logic [255:0] inv_mod_r(input logic [255:0] n);
        logic [255:0] x;
        x = n;
        for (int i = 0; i < 8; i++) x = x * (256'd2 - n * x);
        return x;
    endfunction

    // Whole-operand Montgomery formula: (T + k*N) / 2^256 with k = -T*N^-1 mod 2^256
    function automatic logic [256:0] redc_raw(input logic [511:0] t, input logic [255:0] n);
        logic [255:0] k;
        logic [511:0] kn;
        logic [513:0] s;
        k  = 256'd0 - t[255:0] * inv_mod_r(n);
        kn = {256'd0, k} * {256'd0, n};
        s  = {2'b00, t} + {2'b00, kn};
        return s[512:256];
    endfunction

    task automatic run_op(input string tag, input logic [511:0] t, input logic [255:0] n,
                          input int hold, output logic [255:0] res);
        logic [255:0] ninv;
        int lat;
        ninv = 256'd0 - inv_mod_r(n);
        t_in = t;
        n_in = n;
        n0_inv = ninv[W-1:0];
        in_valid = 1'b1;
        chk({tag, " in_ready before accept"}, 512'(in_ready), 512'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_in = rand512();
        n_in = rand512() >> 256;
        n0_inv = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({tag, " in_ready busy"}, 512'(in_ready), 512'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 512'(lat), 512'(LAT));
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold out_valid"}, 512'(out_valid), 512'd1);
            chk({tag, " hold out_data"}, 512'(out_data), 512'(res));
            chk({tag, " hold in_ready"}, 512'(in_ready), 512'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release out_valid"}, 512'(out_valid), 512'd0);
        chk({tag, " release in_ready"}, 512'(in_ready), 512'd1);
    endtask

    task automatic check_result(input string tag, input logic [255:0] res,
                                input logic [511:0] t, input logic [255:0] n);
        logic [256:0] raw;
        logic [255:0] gold;
        raw = redc_raw(t, n);
        gold = (raw >= {1'b0, n}) ? 256'(raw - {1'b0, n}) : raw[255:0];
        if (raw >= {1'b0, n}) sub_hits++;
`ifdef MONT_REDC_LAZY_EN
        chk({tag, " below 2N"}, 512'(({1'b0, res}) < ({1'b0, n} << 1)), 512'd1);
        chk({tag, " congruent"}, 512'(res % n), 512'(gold));
`else
        chk({tag, " result"}, 512'(res), 512'(gold));
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] np;
        logic [255:0] n;
        logic [511:0] t;
        logic [255:0] res;

        np = (256'd1 << 255) - 256'd19;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        t_in = '0;
        n_in = '0;
        n0_inv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 512'(in_ready), 512'd1);
        chk("reset out_valid", 512'(out_valid), 512'd0);
        chk("reset out_data", 512'(out_data), 512'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        t = {256'd5, 256'd0};
        run_op("t=5R", t, np, 3, res);
        check_result("t=5R", res, t, np);
`ifndef MONT_REDC_LAZY_EN
        chk("t=5R const", 512'(res), 512'd5);
`endif

        t = {256'd0, np};
        run_op("t=N", t, np, 0, res);
        check_result("t=N", res, t, np);
`ifndef MONT_REDC_LAZY_EN
        chk("t=N const", 512'(res), 512'd0);
`endif

        t = '0;
        run_op("t=0", t, np, 0, res);
        check_result("t=0", res, t, np);
        chk("t=0 const", 512'(res), 512'd0);

        t = {np - 256'd1, 256'd0};
        run_op("t=(N-1)R", t, np, 1, res);
        check_result("t=(N-1)R", res, t, np);
`ifndef MONT_REDC_LAZY_EN
        chk("t=(N-1)R const", 512'(res), 512'(np - 256'd1));
`endif

        // 5R + N reduces to N+5 before the final subtract
        t = {256'd5, np};
        run_op("t=5R+N", t, np, 0, res);
        check_result("t=5R+N", res, t, np);
`ifndef MONT_REDC_LAZY_EN
        chk("t=5R+N const", 512'(res), 512'd5);
`endif

        t_in = rand512();
        n_in = np;
        n0_inv = W'($urandom);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid-op reset in_ready", 512'(in_ready), 512'd1);
        chk("mid-op reset out_valid", 512'(out_valid), 512'd0);
        chk("mid-op reset out_data", 512'(out_data), 512'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        t = {256'd7, 256'd0};
        run_op("t=7R after reset", t, np, 0, res);
        check_result("t=7R after reset", res, t, np);
        chk("t=7R const", 512'(res), 512'd7);

        for (int i = 0; i < N_RND; i++) begin
`ifdef MONT_REDC_LAZY_EN
            n = (rand512() >> 257) | 256'd1;
`else
            n = (i % 2 == 0) ? np : (256'(rand512()) | 256'd1);
`endif
            t = rand512() % {n, 256'd0};
            run_op("random", t, n, i % 3, res);
            check_result("random", res, t, n);
        end

        chk("subtract path exercised", 512'(sub_hits > 0), 512'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
